mux_select_arbiter: RTL

//   Upstream control stage for the 2x1 high-enable multiplexer: drives its select and enable inputs.
//   - Arbitrates between two requesters (A, B) with round-robin fairness and a bounded burst length.
//   - select=0 routes a, select=1 routes b; enable=0 forces the mux output to 0.
//   - All outputs are registered and glitch-free.

---
 rtl/mux_select_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mux_select_arbiter.sv
// rtl/mux_select_arbiter.sv - round-robin, burst-bounded select/enable driver for a 2x1 mux.
// Optional SWITCH_GAP_EN inserts one enable=0 GAP cycle on every A<->B switch.
module mux_select_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    output logic             select,
    output logic             enable,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_A = 2'd1;
    localparam logic [1:0] SERVE_B = 2'd2;
`ifdef SWITCH_GAP_EN
    localparam logic [1:0] GAP     = 2'd3;
`endif
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic [1:0]       state_q, state_d;
    logic             last_b_q, last_b_d;
    logic             select_q, select_d;
    logic             enable_q, enable_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic cur_b, own_req, oth_req, at_max, idle_pick_b;
    logic go, go_b;

    assign cur_b       = (state_q == SERVE_B);
    assign own_req     = cur_b ? req_b : req_a;
    assign oth_req     = cur_b ? req_a : req_b;
    assign at_max      = (beat_q == MAX_CNT);
    // On a tie the side that was not served last wins; a lone requester always wins.
    assign idle_pick_b = req_b & (~req_a | ~last_b_q);

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        select_d = select_q;
        enable_d = 1'b0;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        beat_d   = '0;
        go       = 1'b0;
        go_b     = 1'b0;

        case (state_q)
            SERVE_A, SERVE_B: begin
                if (!own_req || (at_max && oth_req)) begin
                    if (oth_req) begin
`ifdef SWITCH_GAP_EN
                        state_d  = GAP;
                        select_d = ~cur_b;
`else
                        go   = 1'b1;
                        go_b = ~cur_b;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    enable_d = 1'b1;
                    gnt_a_d  = ~cur_b;
                    gnt_b_d  = cur_b;
                    beat_d   = at_max ? CNT_W'(1) : beat_q + CNT_W'(1);
                end
            end
            default: begin
                // GAP shares IDLE arbitration: last_served still names the side
                // being left, so a tie resolves to the switch target.
                if (req_a || req_b) begin
                    go   = 1'b1;
                    go_b = idle_pick_b;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        if (go) begin
            state_d  = go_b ? SERVE_B : SERVE_A;
            last_b_d = go_b;
            select_d = go_b;
            enable_d = 1'b1;
            gnt_a_d  = ~go_b;
            gnt_b_d  = go_b;
            beat_d   = CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            select_q <= 1'b0;
            enable_q <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            select_q <= select_d;
            enable_q <= enable_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            beat_q   <= beat_d;
        end
    end

    assign select   = select_q;
    assign enable   = enable_q;
    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign beat_cnt = beat_q;

endmodule
